req_priority_arbiter: RTL and testbench

- Sequential arbiter that shares one downstream resource among N requesters, using the codebase's priority-encoding convention (highest index wins).
- Registers the grant and holds it until the owner drops its request or a hold timeout expires.
- Optionally rotates priority (round-robin) so low-index requesters cannot starve.
- Sits between request sources (channels, interrupt lines) and a shared bus or engine.

---
 rtl/req_priority_arbiter_if.sv | 41 ++++
 rtl/req_priority_arbiter.sv | 150 +++++++++++++++
 tb/tb_req_priority_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/req_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : req_priority_arbiter_if
// Description : Request/grant bundle between N requesters and the shared
//               resource arbiter.
//                 req         - request vector, bit i = requester i wants it
//                 grant       - one-hot registered grant (zero when idle)
//                 grant_id    - binary index of the current owner
//                 grant_valid - high while any grant bit is set
//                 timeout     - one-cycle pulse on forced release
//               Modports: master = request side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface req_priority_arbiter_if #(
    parameter int N = 8
) ();
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_valid;
    logic            timeout;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/req_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : req_priority_arbiter
// Description : Registered N-way arbiter for one shared resource. The highest
//               requesting index wins; the grant is held until the owner
//               drops its request or MAX_HOLD consecutive cycles elapse
//               (forced release with a one-cycle timeout pulse). Every
//               release is followed by exactly one idle cycle.
//               Optional build macro REQ_ARB_ROUND_ROBIN_EN rotates the
//               search start to just below the previous winner.
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset
//               bus - req_priority_arbiter_if.slave (req, grant, grant_id,
//                     grant_valid, timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module req_priority_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    req_priority_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N);
    localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [HC_W-1:0] C_MAX_HOLD   = HC_W'(MAX_HOLD);
    localparam bit              C_TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [N-1:0]    C_ONE_HOT0   = {{(N-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]      state_q,    state_d;
    logic [N-1:0]    grant_q,    grant_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0] last_id_q,  last_id_d;
    logic            timeout_q,  timeout_d;

    logic [ID_W-1:0] win_id;
    logic            owner_req;

    // The owner's request is read through the one-hot grant rather than by
    // indexing with grant_id, so non-power-of-two N never selects a
    // nonexistent bit.
    assign owner_req = |(bus.req & grant_q);

`ifdef REQ_ARB_ROUND_ROBIN_EN
    // Rank of index j = distance below last_id in descending, wrapping order
    // (last_id-1 has rank 0, last_id itself has rank N-1). Lowest rank wins.
    int best_rank;
    int rank;
    always_comb begin
        win_id    = '0;
        best_rank = N;
        rank      = 0;
        for (int j = 0; j < N; j++) begin
            rank = (int'(last_id_q) + N - 1 - j) % N;
            if (bus.req[j] && (rank < best_rank)) begin
                best_rank = rank;
                win_id    = ID_W'(j);
            end
        end
    end
`else
    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        win_id = '0;
        for (int j = 0; j < N; j++) begin
            if (bus.req[j]) begin
                win_id = ID_W'(j);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
                if (|bus.req) begin
                    state_d    = S_BUSY;
                    grant_d    = C_ONE_HOT0 << win_id;
                    grant_id_d = win_id;
                    hold_cnt_d = HC_W'(1);
                    last_id_d  = win_id;
                end
            end
            S_BUSY: begin
                if (!owner_req) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    hold_cnt_d = '0;
                end else if (C_TIMEOUT_EN && (hold_cnt_q == C_MAX_HOLD)) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else if (hold_cnt_q != {HC_W{1'b1}}) begin
                    // Saturating: with the timeout disabled the count
                    // parks at all-ones instead of wrapping.
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_cnt_q <= '0;
            last_id_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            hold_cnt_q <= hold_cnt_d;
            last_id_q  <= last_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = |grant_q;
    assign bus.timeout     = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_req_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_priority_arbiter
// Description : Directed self-checking bench. Three arbiters share clk/rst:
//               dut_a (MAX_HOLD=16) for reset/handshake/priority,
//               dut_b (MAX_HOLD=4) for the hold timeout,
//               dut_c (MAX_HOLD=2) for rotation and reset of last_id.
//               Expected values follow REQ_ARB_ROUND_ROBIN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_priority_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    req_priority_arbiter_if #(.N(8)) ifa ();
    req_priority_arbiter_if #(.N(8)) ifb ();
    req_priority_arbiter_if #(.N(8)) ifc ();

    req_priority_arbiter #(.N(8), .MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    req_priority_arbiter #(.N(8), .MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
    req_priority_arbiter #(.N(8), .MAX_HOLD(2))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.req = 8'hFF;
        tick();
        tick();
        total++; if (ifa.grant !== 8'h00) begin bad++; $display("FAIL reset_grant: got %h want 00", ifa.grant); end
        total++; if (ifa.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ifa.grant_valid); end
        total++; if (ifa.grant_id !== 3'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", ifa.grant_id); end
        total++; if (ifa.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", ifa.timeout); end
        rst = 1'b0;
        tick();
        total++; if (ifa.grant !== 8'h80) begin bad++; $display("FAIL post_reset_grant: got %h want 80", ifa.grant); end
        total++; if (ifa.grant_id !== 3'd7) begin bad++; $display("FAIL post_reset_id: got %0d want 7", ifa.grant_id); end
        total++; if (ifa.grant_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid: got %b want 1", ifa.grant_valid); end
        ifa.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_single();
        ifa.req = 8'b0000_0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (ifa.grant !== 8'h04 || ifa.grant_id !== 3'd2 || ifa.timeout !== 1'b0)
                begin bad++; $display("FAIL single_hold[%0d]: got grant=%h id=%0d to=%b want 04/2/0", c, ifa.grant, ifa.grant_id, ifa.timeout); end
        end
        ifa.req = 8'h00;
        tick();
        total++; if (ifa.grant !== 8'h00 || ifa.grant_valid !== 1'b0 || ifa.grant_id !== 3'd0 || ifa.timeout !== 1'b0)
            begin bad++; $display("FAIL single_release: got grant=%h v=%b id=%0d to=%b want 00/0/0/0", ifa.grant, ifa.grant_valid, ifa.grant_id, ifa.timeout); end
        ifa.req = 8'h04;
        tick();
        total++; if (ifa.grant !== 8'h04) begin bad++; $display("FAIL single_gap_one_cycle: got %h want 04", ifa.grant); end
        ifa.req = 8'h00;
        tick();
        total++; if (ifa.grant !== 8'h00) begin bad++; $display("FAIL single_drop2: got %h want 00", ifa.grant); end
        tick();
    endtask

    task automatic test_priority();
        ifa.req = 8'h01;
        tick();
        total++; if (ifa.grant !== 8'h01 || ifa.grant_id !== 3'd0 || ifa.grant_valid !== 1'b1)
            begin bad++; $display("FAIL prio_low_grant: got grant=%h id=%0d v=%b want 01/0/1", ifa.grant, ifa.grant_id, ifa.grant_valid); end
        ifa.req = 8'h81;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (ifa.grant !== 8'h01) begin bad++; $display("FAIL prio_no_preempt[%0d]: got %h want 01", c, ifa.grant); end
        end
        ifa.req = 8'h80;
        tick();
        total++; if (ifa.grant !== 8'h00) begin bad++; $display("FAIL prio_gap: got %h want 00", ifa.grant); end
        tick();
        total++; if (ifa.grant !== 8'h80 || ifa.grant_id !== 3'd7)
            begin bad++; $display("FAIL prio_high_grant: got grant=%h id=%0d want 80/7", ifa.grant, ifa.grant_id); end
        ifa.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        ifb.req = 8'h10;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                total++; if (ifb.grant !== 8'h10 || ifb.grant_id !== 3'd4 || ifb.timeout !== 1'b0)
                    begin bad++; $display("FAIL timeout_hold[%0d.%0d]: got grant=%h id=%0d to=%b want 10/4/0", p, c, ifb.grant, ifb.grant_id, ifb.timeout); end
            end
            tick();
            total++; if (ifb.grant !== 8'h00 || ifb.grant_valid !== 1'b0 || ifb.timeout !== 1'b1)
                begin bad++; $display("FAIL timeout_pulse[%0d]: got grant=%h v=%b to=%b want 00/0/1", p, ifb.grant, ifb.grant_valid, ifb.timeout); end
        end
        tick();
        total++; if (ifb.grant !== 8'h10 || ifb.timeout !== 1'b0)
            begin bad++; $display("FAIL timeout_regrant: got grant=%h to=%b want 10/0", ifb.grant, ifb.timeout); end
        ifb.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [2:0] exp_ids [6];
`ifdef REQ_ARB_ROUND_ROBIN_EN
        exp_ids = '{3'd7, 3'd3, 3'd0, 3'd7, 3'd3, 3'd0};
`else
        exp_ids = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        ifc.req = 8'h89;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                total++; if (ifc.grant_id !== exp_ids[p] || ifc.grant !== (8'h01 << exp_ids[p]) || ifc.timeout !== 1'b0)
                    begin bad++; $display("FAIL rotate_grant[%0d.%0d]: got grant=%h id=%0d to=%b want id=%0d", p, c, ifc.grant, ifc.grant_id, ifc.timeout, exp_ids[p]); end
            end
            tick();
            total++; if (ifc.grant !== 8'h00 || ifc.timeout !== 1'b1)
                begin bad++; $display("FAIL rotate_timeout[%0d]: got grant=%h to=%b want 00/1", p, ifc.grant, ifc.timeout); end
        end
        ifc.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        ifa.req = 8'h20;
        ifc.req = 8'h08;
        tick();
        total++; if (ifa.grant !== 8'h20) begin bad++; $display("FAIL mid_a_grant: got %h want 20", ifa.grant); end
        total++; if (ifc.grant_id !== 3'd3) begin bad++; $display("FAIL mid_c_grant: got id=%0d want 3", ifc.grant_id); end
        tick();
        rst = 1'b1;
        tick();
        // dut_c would have timed out on this edge; reset must win.
        total++; if (ifa.grant !== 8'h00 || ifa.timeout !== 1'b0)
            begin bad++; $display("FAIL mid_a_reset: got grant=%h to=%b want 00/0", ifa.grant, ifa.timeout); end
        total++; if (ifc.grant !== 8'h00 || ifc.timeout !== 1'b0)
            begin bad++; $display("FAIL mid_c_reset: got grant=%h to=%b want 00/0", ifc.grant, ifc.timeout); end
        rst = 1'b0;
        ifc.req = 8'h89;
        tick();
        total++; if (ifa.grant !== 8'h20 || ifa.grant_id !== 3'd5)
            begin bad++; $display("FAIL mid_a_regrant: got grant=%h id=%0d want 20/5", ifa.grant, ifa.grant_id); end
        // last_id back at 0 means the search restarts from index 7.
        total++; if (ifc.grant_id !== 3'd7) begin bad++; $display("FAIL mid_c_last_id_reset: got id=%0d want 7", ifc.grant_id); end
        ifa.req = 8'h00;
        ifc.req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        ifa.req = 8'h00;
        ifb.req = 8'h00;
        ifc.req = 8'h00;
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_rotation();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
